// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding and default widths for the write-back skid stage.
package wb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_e;

    function automatic logic [1:0] occ_of(wb_state_e s);
        return s == TWO ? 2'd2 : s == ONE ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/wb_skid_stage_if.sv
// wb_skid_stage_if: MEM-side and register-file-side handshake bundle of the write-back stage.
interface wb_skid_stage_if
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_wr_en;
    logic [REG_W-1:0]  in_wr_reg;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_mem_data;
    logic              in_mem_to_reg;
    logic              out_valid;
    logic              out_ready;
    logic              out_wr_en;
    logic [REG_W-1:0]  out_wr_reg;
    logic [DATA_W-1:0] out_wb_data;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_wr_en, in_wr_reg, in_alu_res, in_mem_data, in_mem_to_reg, out_ready,
        input  in_ready, out_valid, out_wr_en, out_wr_reg, out_wb_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_wr_en, in_wr_reg, in_alu_res, in_mem_data, in_mem_to_reg, out_ready,
        output in_ready, out_valid, out_wr_en, out_wr_reg, out_wb_data, occupancy
    );

endinterface

// File: rtl/wb_entry_reg.sv
// wb_entry_reg: load-enabled payload register with asynchronous active-low clear.
module wb_entry_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else if (ld_i) q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/wb_skid_stage.sv
// wb_skid_stage: MEM->register-file write-back stage with optional 2-entry skid buffer.
module wb_skid_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter bit SKID_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    wb_skid_stage_if.slave wb
);

    // Entry layout: {wr_en, wr_reg, alu_res, mem_data, mem_to_reg}
    localparam int PW = 2 * DATA_W + REG_W + 2;

    wb_state_e     state_q;
    logic [PW-1:0] in_ent, head_d, head_q, skid_q;
    logic          head_ld, skid_ld, in_ready, out_valid, in_fire, out_fire;

    assign in_ent    = {wb.in_wr_en, wb.in_wr_reg, wb.in_alu_res, wb.in_mem_data, wb.in_mem_to_reg};
    assign out_valid = state_q != EMPTY;
    // With the skid buffer, ready is decoded from state only so out_ready never reaches in_ready.
    assign in_ready  = SKID_EN ? rst_n && state_q != TWO : rst_n && (!out_valid || wb.out_ready);
    assign in_fire   = wb.in_valid && in_ready;
    assign out_fire  = out_valid && wb.out_ready;

    assign head_ld = !wb.flush && (state_q == TWO ? out_fire : state_q == ONE ? in_fire && out_fire : in_fire);
    assign skid_ld = !wb.flush && state_q == ONE && in_fire && !out_fire;
    assign head_d  = state_q == TWO ? skid_q : in_ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else state_q <= wb.flush         ? EMPTY :
                        state_q == EMPTY ? (in_fire ? ONE : EMPTY) :
                        state_q == ONE   ? (in_fire && !out_fire ? TWO : !in_fire && out_fire ? EMPTY : ONE) :
                                           (out_fire ? ONE : TWO);
    end

    wb_entry_reg #(.W(PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (head_ld),
        .d_i   (head_d),
        .q_o   (head_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            wb_entry_reg #(.W(PW)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .ld_i  (skid_ld),
                .d_i   (in_ent),
                .q_o   (skid_q)
            );
        end else begin : g_noskid
            assign skid_q = '0;
        end
    endgenerate

    assign wb.in_ready    = in_ready;
    assign wb.out_valid   = out_valid;
    assign wb.out_wr_en   = out_valid && head_q[PW-1];
    assign wb.out_wr_reg  = head_q[PW-2 -: REG_W];
    assign wb.out_wb_data = head_q[0] ? head_q[DATA_W:1] : head_q[2*DATA_W:DATA_W+1];
    assign wb.occupancy   = occ_of(state_q);

endmodule

// File: tb/tb_wb_skid_stage.sv
// tb_wb_skid_stage: checks both buffer variants against a queue model of the write-back stage.
module tb_wb_skid_stage;

    typedef struct packed {
        logic        we;
        logic [3:0]  rg;
        logic [15:0] alu;
        logic [15:0] mem;
        logic        m2r;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_skid_stage_if #(.DATA_W(16), .REG_W(4)) a ();
    wb_skid_stage_if #(.DATA_W(16), .REG_W(4)) b ();

    wb_skid_stage #(.DATA_W(16), .REG_W(4), .SKID_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .wb(a));
    wb_skid_stage #(.DATA_W(16), .REG_W(4), .SKID_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .wb(b));

    ent_t qa[$], qb[$];
    logic [15:0] acc_q[$], del_q[$];
    ent_t cur;
    logic iv = 1'b0, fl = 1'b0, ordy = 1'b0, rec = 1'b0;
    int nvec = 0, nmis = 0;

    function automatic logic [15:0] wbv(ent_t e);
        return e.m2r ? e.mem : e.alu;
    endfunction

    // Expected {in_ready, out_valid, occupancy, wr_en, wr_reg, wb_data}; payload only meaningful when valid.
    function automatic logic [24:0] exp_a();
        int n = qa.size();
        logic r = rst_n && n < 2;
        if (n == 0) return {r, 1'b0, 2'(n), 1'b0, 4'd0, 16'd0};
        return {r, 1'b1, 2'(n), qa[0].we, qa[0].rg, wbv(qa[0])};
    endfunction

    function automatic logic [24:0] exp_b();
        int n = qb.size();
        logic r = rst_n && (n == 0 || ordy);
        if (n == 0) return {r, 1'b0, 2'(n), 1'b0, 4'd0, 16'd0};
        return {r, 1'b1, 2'(n), qb[0].we, qb[0].rg, wbv(qb[0])};
    endfunction

    function automatic logic [24:0] obs_a();
        return {a.in_ready, a.out_valid, a.occupancy, a.out_wr_en,
                a.out_valid ? a.out_wr_reg : 4'd0, a.out_valid ? a.out_wb_data : 16'd0};
    endfunction

    function automatic logic [24:0] obs_b();
        return {b.in_ready, b.out_valid, b.occupancy, b.out_wr_en,
                b.out_valid ? b.out_wr_reg : 4'd0, b.out_valid ? b.out_wb_data : 16'd0};
    endfunction

    task automatic apply();
        a.in_valid = iv; a.flush = fl; a.out_ready = ordy;
        a.in_wr_en = cur.we; a.in_wr_reg = cur.rg; a.in_alu_res = cur.alu;
        a.in_mem_data = cur.mem; a.in_mem_to_reg = cur.m2r;
        b.in_valid = iv; b.flush = fl; b.out_ready = ordy;
        b.in_wr_en = cur.we; b.in_wr_reg = cur.rg; b.in_alu_res = cur.alu;
        b.in_mem_data = cur.mem; b.in_mem_to_reg = cur.m2r;
    endtask

    task automatic rand_ent();
        cur.we  = 1'($urandom_range(0, 1));
        cur.rg  = 4'($urandom);
        cur.alu = 16'($urandom);
        cur.mem = 16'($urandom);
        cur.m2r = 1'($urandom_range(0, 1));
    endtask

    // Advance one clock: the model moves at the rising edge, the bench returns at the falling edge.
    task automatic tick();
        logic fa, oa, fb, ob;
        fa = iv && qa.size() < 2;
        oa = qa.size() > 0 && ordy;
        fb = iv && (qb.size() == 0 || ordy);
        ob = qb.size() > 0 && ordy;
        if (rec && fb && !fl) acc_q.push_back(wbv(cur));
        if (rec && b.out_valid && ordy && !fl) del_q.push_back(b.out_wb_data);
        @(posedge clk);
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (oa) void'(qa.pop_front());
            if (fa) qa.push_back(cur);
            if (ob) void'(qb.pop_front());
            if (fb) qb.push_back(cur);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv = 0; fl = 0; ordy = 0; cur = '0;
        apply();
        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if ({a.in_ready, a.out_valid, a.out_wr_en, a.occupancy, a.out_wr_reg, a.out_wb_data} !== 26'd0) begin
            nmis++;
            $display("FAIL reset_a got %h exp 0", {a.in_ready, a.out_valid, a.out_wr_en, a.occupancy, a.out_wr_reg, a.out_wb_data});
        end
        nvec++;
        if ({b.in_ready, b.out_valid, b.out_wr_en, b.occupancy, b.out_wr_reg, b.out_wb_data} !== 26'd0) begin
            nmis++;
            $display("FAIL reset_b got %h exp 0", {b.in_ready, b.out_valid, b.out_wr_en, b.occupancy, b.out_wr_reg, b.out_wb_data});
        end
        rst_n = 1'b1;
        #1;
        nvec++;
        if ({a.in_ready, b.in_ready, a.occupancy, b.occupancy} !== 6'b110000) begin
            nmis++;
            $display("FAIL reset_release got %b exp 110000", {a.in_ready, b.in_ready, a.occupancy, b.occupancy});
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        cur = {1'b1, 4'd3, 16'h1234, 16'h5555, 1'b0}; iv = 1; ordy = 1;
        apply(); #1;
        nvec++;
        if (obs_a() !== exp_a()) begin nmis++; $display("FAIL basic_accept got %h exp %h", obs_a(), exp_a()); end
        tick();
        iv = 0; apply(); #1;
        nvec++;
        if (obs_a() !== {1'b1, 1'b1, 2'd1, 1'b1, 4'd3, 16'h1234}) begin
            nmis++; $display("FAIL basic_out_a got %h exp %h", obs_a(), {1'b1, 1'b1, 2'd1, 1'b1, 4'd3, 16'h1234});
        end
        nvec++;
        if (obs_b() !== {1'b1, 1'b1, 2'd1, 1'b1, 4'd3, 16'h1234}) begin
            nmis++; $display("FAIL basic_out_b got %h exp %h", obs_b(), {1'b1, 1'b1, 2'd1, 1'b1, 4'd3, 16'h1234});
        end
        tick(); #1;
        nvec++;
        if (obs_a() !== exp_a()) begin nmis++; $display("FAIL basic_drain got %h exp %h", obs_a(), exp_a()); end
    endtask

    task automatic test_mem_sel();
        cur = {1'b1, 4'd5, 16'h0F0F, 16'hBEEF, 1'b1}; iv = 1; ordy = 1;
        apply(); tick();
        iv = 0; apply(); #1;
        nvec++;
        if ({a.out_wb_data, b.out_wb_data} !== {16'hBEEF, 16'hBEEF}) begin
            nmis++; $display("FAIL mem_sel got %h/%h exp beef", a.out_wb_data, b.out_wb_data);
        end
        tick();
    endtask

    task automatic test_skid();
        ordy = 0; iv = 1;
        cur = {1'b1, 4'd1, 16'h0001, 16'h0000, 1'b0};
        apply(); tick();
        cur = {1'b1, 4'd2, 16'h0002, 16'h0000, 1'b0};
        apply(); #1;
        nvec++;
        if (obs_b() !== exp_b()) begin nmis++; $display("FAIL skid_b_stall got %h exp %h", obs_b(), exp_b()); end
        tick();
        iv = 0; apply(); #1;
        nvec++;
        if ({a.occupancy, a.in_ready} !== 3'b100) begin
            nmis++; $display("FAIL skid_full got %b exp 100", {a.occupancy, a.in_ready});
        end
        ordy = 1; apply(); #1;
        nvec++;
        if ({a.out_valid, a.out_wb_data} !== {1'b1, 16'h0001}) begin
            nmis++; $display("FAIL skid_first got %h exp 10001", {a.out_valid, a.out_wb_data});
        end
        tick(); #1;
        nvec++;
        if ({a.out_valid, a.out_wb_data, a.occupancy} !== {1'b1, 16'h0002, 2'd1}) begin
            nmis++; $display("FAIL skid_second got %h exp %h", {a.out_valid, a.out_wb_data, a.occupancy}, {1'b1, 16'h0002, 2'd1});
        end
        tick(); #1;
        nvec++;
        if (obs_a() !== exp_a()) begin nmis++; $display("FAIL skid_drain got %h exp %h", obs_a(), exp_a()); end
    endtask

    task automatic test_flush();
        ordy = 0; iv = 1;
        for (int i = 0; i < 2; i++) begin rand_ent(); apply(); tick(); end
        cur = {1'b1, 4'd7, 16'h7777, 16'h7777, 1'b0}; fl = 1;
        apply(); #1;
        nvec++;
        if (obs_a() !== exp_a()) begin nmis++; $display("FAIL flush_pre got %h exp %h", obs_a(), exp_a()); end
        tick();
        fl = 0; iv = 0; ordy = 1; apply(); #1;
        nvec++;
        if (obs_a() !== {1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 16'd0}) begin
            nmis++; $display("FAIL flush_a got %h exp %h", obs_a(), {1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 16'd0});
        end
        nvec++;
        if ({b.out_valid, b.occupancy, b.out_wr_en} !== 4'd0) begin
            nmis++; $display("FAIL flush_b got %b exp 0000", {b.out_valid, b.occupancy, b.out_wr_en});
        end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            nvec++;
            if (a.out_valid !== 1'b0 || b.out_valid !== 1'b0) begin
                nmis++; $display("FAIL flush_ghost got %b%b exp 00", a.out_valid, b.out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        ordy = 0; iv = 1;
        for (int i = 0; i < 2; i++) begin rand_ent(); apply(); tick(); end
        iv = 0; apply();
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({a.out_valid, a.occupancy, b.out_valid, a.out_wr_en} !== 5'd0) begin
            nmis++; $display("FAIL async_reset got %b exp 00000", {a.out_valid, a.occupancy, b.out_valid, a.out_wr_en});
        end
        qa.delete(); qb.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        nvec++;
        if (obs_a() !== exp_a()) begin nmis++; $display("FAIL async_release_a got %h exp %h", obs_a(), exp_a()); end
        nvec++;
        if (obs_b() !== exp_b()) begin nmis++; $display("FAIL async_release_b got %h exp %h", obs_b(), exp_b()); end
        @(negedge clk);
    endtask

    task automatic test_noskid_toggle();
        logic ok;
        acc_q.delete(); del_q.delete(); rec = 1; iv = 1;
        for (int i = 0; i < 8; i++) begin
            ordy = (i % 2 == 0);
            rand_ent(); apply(); #1;
            nvec++;
            if (obs_b() !== exp_b()) begin nmis++; $display("FAIL toggle_b[%0d] got %h exp %h", i, obs_b(), exp_b()); end
            nvec++;
            if (obs_a() !== exp_a()) begin nmis++; $display("FAIL toggle_a[%0d] got %h exp %h", i, obs_a(), exp_a()); end
            tick();
        end
        iv = 0; ordy = 1; apply();
        repeat (3) tick();
        rec = 0;
        ok = acc_q.size() == del_q.size() && acc_q.size() > 0;
        if (ok) for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] !== del_q[i]) ok = 0;
        nvec++;
        if (!ok) begin
            nmis++; $display("FAIL toggle_order got %0d delivered exp %0d accepted in order", del_q.size(), acc_q.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            iv = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 19) == 0);
            rand_ent(); apply(); #1;
            nvec++;
            if (obs_a() !== exp_a()) begin nmis++; $display("FAIL rand_a[%0d] got %h exp %h", i, obs_a(), exp_a()); end
            nvec++;
            if (obs_b() !== exp_b()) begin nmis++; $display("FAIL rand_b[%0d] got %h exp %h", i, obs_b(), exp_b()); end
            tick();
        end
        fl = 0; iv = 0; apply();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mem_sel();
        test_skid();
        test_flush();
        test_async_reset();
        test_noskid_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
